frag_head_inserter: RTL



---
 rtl/frag_head_inserter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/frag_head_inserter.sv
// Fragment header inserter: prepends a 5/9-byte header and appends CRC_BYTES zero bytes,
// repacking header ++ payload ++ tail MSB-first into full output beats.
module frag_head_inserter #(
   parameter int DATA_BYTES = 4,
   parameter int CRC_BYTES  = 4,
   localparam int KW = $clog2(DATA_BYTES + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
   input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   input  logic [15:0]             frame_type,
   input  logic [11:0]             frag_len,
   input  logic [6:0]              frag_cnt,
   input  logic                    frag_done,
   input  logic [11:0]             aggr_offset,
   output logic [8*DATA_BYTES-1:0] m_axis_tdata,
   output logic [KW-1:0]           m_axis_tkeep,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic                    err_keep
);
   // state | meaning
   // IDLE  | no frame in progress, next accepted beat carries the header
   // HDR   | header bytes still waiting in the buffer
   // DATA  | header emitted, streaming payload
   // TAIL  | tlast accepted, draining buffer incl. CRC zero bytes

   localparam int BUF_BYTES = 2*DATA_BYTES + 9 + CRC_BYTES;
   localparam int APP_BYTES = DATA_BYTES + 9 + CRC_BYTES;
   localparam int CW        = $clog2(BUF_BYTES + 1);

   typedef enum logic [1:0] {IDLE, HDR, DATA, TAIL} state_t;

   state_t        state, state_nxt;
   logic [7:0]    byte_buf [BUF_BYTES];
   logic [7:0]    buf_nxt  [BUF_BYTES];
   logic [7:0]    comb_buf [BUF_BYTES];
   logic [7:0]    app      [APP_BYTES];
   logic [7:0]    hdr      [9];
   logic [CW-1:0] cnt;
   logic [3:0]    hdr_pend, hdr_pend_nxt;
   logic [8*DATA_BYTES-1:0] out_data;
   logic          acc, keep_bad, tail_bad, tail_done, out_free, load_last;
   int            room, lead, hdr_n, pay_n, app_n, comb_n, pop_n, pend_base;

   always_comb begin
      room = int'(cnt) + DATA_BYTES + CRC_BYTES + ((state == IDLE) ? 9 : 0);
      s_axis_tready = !rst && (state != TAIL) && (room <= BUF_BYTES);
      acc = s_axis_tvalid && s_axis_tready;
      lead = 0;
      tail_bad = 1'b0;
      for (int i = 0; i < DATA_BYTES; i++)
         if (s_axis_tkeep[DATA_BYTES-1-i] && lead == i) lead = i + 1;
      for (int i = 0; i < DATA_BYTES; i++)
         if (i >= lead && s_axis_tkeep[DATA_BYTES-1-i]) tail_bad = 1'b1;
      // a malformed non-last beat is still taken as a full beat
      pay_n    = s_axis_tlast ? lead : DATA_BYTES;
      keep_bad = s_axis_tlast ? tail_bad : (lead != DATA_BYTES);
   end

   always_comb begin
      hdr[0] = {4'b0, frag_len[11:8]};
      hdr[1] = frag_len[7:0];
      hdr[2] = frame_type[15:8];
      hdr[3] = frame_type[7:0];
      hdr[4] = {frag_cnt, frag_done};
      hdr[5] = frame_type[15:8];
      hdr[6] = frame_type[7:0];
      hdr[7] = {4'b0, aggr_offset[11:8]};
      hdr[8] = aggr_offset[7:0];
      hdr_n  = (state == IDLE) ? (frame_type[0] ? 9 : 5) : 0;
      app_n  = acc ? hdr_n + pay_n + (s_axis_tlast ? CRC_BYTES : 0) : 0;
      for (int j = 0; j < APP_BYTES; j++) app[j] = 8'h00;
      for (int j = 0; j < 9; j++)
         if (j < hdr_n) app[j] = hdr[j];
      for (int k = 0; k < DATA_BYTES; k++)
         if (k < pay_n) app[hdr_n + k] = s_axis_tdata[8*(DATA_BYTES-1-k) +: 8];
   end

   always_comb begin
      for (int i = 0; i < BUF_BYTES; i++)
         comb_buf[i] = (i < int'(cnt)) ? byte_buf[i] : 8'h00;
      for (int j = 0; j < APP_BYTES; j++)
         if (j < app_n && int'(cnt) + j < BUF_BYTES) comb_buf[int'(cnt) + j] = app[j];
      comb_n    = int'(cnt) + app_n;
      tail_done = (state == TAIL) || (acc && s_axis_tlast);
      out_free  = !m_axis_tvalid || m_axis_tready;
      pop_n     = 0;
      load_last = 1'b0;
      if (out_free) begin
         if (tail_done && comb_n != 0 && comb_n <= DATA_BYTES) begin
            pop_n     = comb_n;
            load_last = 1'b1;
         end else if (comb_n >= DATA_BYTES) begin
            pop_n = DATA_BYTES;
         end
      end
      out_data = '0;
      for (int k = 0; k < DATA_BYTES; k++)
         if (k < pop_n) out_data[8*(DATA_BYTES-1-k) +: 8] = comb_buf[k];
      for (int i = 0; i < BUF_BYTES; i++)
         buf_nxt[i] = (i + pop_n < BUF_BYTES) ? comb_buf[i + pop_n] : 8'h00;
   end

   always_comb begin
      pend_base    = (state == IDLE) ? hdr_n : int'(hdr_pend);
      hdr_pend_nxt = 4'((pend_base > pop_n) ? pend_base - pop_n : 0);
      state_nxt    = state;
      case (state)
         IDLE: if (acc) state_nxt = s_axis_tlast ? TAIL : HDR;
         HDR: begin
            if (acc && s_axis_tlast) state_nxt = TAIL;
            else if (hdr_pend_nxt == 4'd0) state_nxt = DATA;
         end
         DATA: if (acc && s_axis_tlast) state_nxt = TAIL;
         TAIL: if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         hdr_pend      <= '0;
         err_keep      <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         for (int i = 0; i < BUF_BYTES; i++) byte_buf[i] <= 8'h00;
      end else begin
         state    <= state_nxt;
         cnt      <= CW'(comb_n - pop_n);
         hdr_pend <= hdr_pend_nxt;
         err_keep <= acc && keep_bad;
         for (int i = 0; i < BUF_BYTES; i++) byte_buf[i] <= buf_nxt[i];
         if (out_free) begin
            m_axis_tvalid <= (pop_n != 0);
            m_axis_tlast  <= load_last;
            m_axis_tdata  <= out_data;
            m_axis_tkeep  <= KW'(pop_n);
         end
      end
   end
endmodule
